peripheral_bus_bridge: RTL and testbench
========================================

Name: peripheral_bus_bridge

Overview:
- Bus-slave front end sitting directly upstream of the peripheral core.
- Accepts single word read/write requests on a valid/ready request channel.
- Decodes each request to either the core's register file or its 256-word memory, generates one-cycle register write strobes and memory accesses, and returns read data and error on a valid/ready response channel.
- One transaction outstanding at a time.

Parameters:
- REGS, 3, number of core registers; register write strobe width.
- ADDRWIDTH, 12, byte address width.
- MEMDEPTH, 256, memory words; the memory window spans MEMDEPTH*4 bytes.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  bridge can accept a request.
- req_write  input  1  1 = write, 0 = read.
- req_addr  input  ADDRWIDTH  byte address.
- req_wdata  input  32  write data.
- resp_valid  output  1  response present.
- resp_ready  input  1  master accepts the response.
- resp_rdata  output  32  read data; 0 on writes and on errors.
- resp_err  output  1  decode or alignment error.
- reg_write_en  output  REGS  one-hot register write strobe.
- reg_data_in  output  32  register write data.
- reg_data_out  input  REGS x 32  register read-back from the core.
- mem_write_en  output  1  memory write strobe.
- mem_address  output  8  memory word address.
- mem_data_in  output  32  memory write data.
- mem_data_out  input  32  memory read data, valid 1 cycle after address.

Behaviour:
- Address map:
  - 0x000-0x7FF: register space; index = addr[10:2].
  - 0x800-0xBFF: memory window; word = addr[9:2].
  - 0xC00-0xFFF: unmapped, error.
  - A register index >= REGS is an error.
- Reset (reset=0, asynchronous) drives:
  - state IDLE;
  - req_ready=0 while asserted, 1 after release;
  - resp_valid=0, resp_rdata=0, resp_err=0;
  - reg_write_en=0, mem_write_en=0;
  - mem_address=0, reg_data_in=0, mem_data_in=0.
  - Reset mid-transaction drops the transaction; no strobe and no response are issued.
- FSM states: IDLE, ACCESS, MEM_WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch write, addr and wdata, then decode.
  - Error request goes directly to RESP with resp_err=1.
  - Otherwise go to ACCESS.
- ACCESS (one cycle; all strobes are registered outputs):
  - Register write: reg_write_en[index]=1 and reg_data_in=wdata for exactly this cycle; next state RESP.
  - Register read: capture reg_data_out[index] into resp_rdata; next state RESP.
  - Memory write: mem_write_en=1, mem_address=word, mem_data_in=wdata; next state RESP.
  - Memory read: mem_address=word, mem_write_en=0; next state MEM_WAIT.
- MEM_WAIT: capture mem_data_out into resp_rdata; next state RESP.
- RESP:
  - resp_valid=1; rdata and err are held stable until resp_ready.
  - On resp_valid & resp_ready, return to IDLE and clear resp_valid.
- Latency from acceptance to first resp_valid:
  - register access: 2 cycles;
  - memory write: 2 cycles;
  - memory read: 3 cycles;
  - error: 1 cycle.
- req_ready=0 outside IDLE; requests presented then are held by the master, not lost.
- Strobes are never asserted for error requests or outside ACCESS.
- resp_ready held low indefinitely stalls the bridge in RESP; no further strobes are issued.
- Back-to-back: the next request can be accepted in the cycle after the response handshake.

Optional Feature:
- Macro: PERIPH_BRIDGE_STRICT_ALIGN_EN.
- Defined: any req_addr[1:0] != 0 is an error (resp_err=1, no access).
- Undefined: addr[1:0] is ignored and the access proceeds at the word address.

Decomposition:
- Package peripheral_bridge_pkg holds:
  - bridge_state_t enum (IDLE, ACCESS, MEM_WAIT, RESP);
  - address-map constants REG_BASE=0x000, MEM_BASE=0x800, MAP_END=0xC00;
  - target enum (TGT_REG, TGT_MEM, TGT_ERR).
- Sub-module peripheral_addr_decode: combinational mapping of addr to target, index and error; this is where the align macro is applied.

Test Plan:
- Write 0x0000_0005 to addr 0x004:
  - reg_write_en=3'b010 for one cycle, reg_data_in=5;
  - response at +2 cycles, err=0, rdata=0.
- Read addr 0x008 with reg_data_out[2]=0x1: resp_rdata=0x0000_0001, err=0, latency 2.
- Write 0xDEAD_BEEF to 0x810, then read 0x810:
  - mem_write_en pulse with mem_address=4;
  - read response rdata=0xDEAD_BEEF at latency 3.
- Accesses to 0x00C (index 3 >= REGS) and 0xC00:
  - resp_err=1, rdata=0, no strobes, latency 1.
- Read 0x000 with resp_ready held low 5 cycles:
  - resp_valid and rdata held stable;
  - req_ready=0 throughout;
  - a second request is accepted only after the handshake.
- Assert reset during ACCESS of a memory write:
  - mem_write_en drops immediately, no response;
  - after release req_ready=1 and outputs are at their reset values.
- With PERIPH_BRIDGE_STRICT_ALIGN_EN defined, addr 0x006 gives err=1; undefined, it writes register 1.

Source files
------------

// File: rtl/peripheral_bus_bridge_pkg.sv
// Shared types and address-map constants for the peripheral bus bridge.
package peripheral_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACCESS   = 2'd1,
        MEM_WAIT = 2'd2,
        RESP     = 2'd3
    } bridge_state_t;

    typedef enum logic [1:0] {
        TGT_REG = 2'd0,
        TGT_MEM = 2'd1,
        TGT_ERR = 2'd2
    } target_t;

    // Byte-address map: registers at the bottom, memory window above,
    // everything from MAP_END upwards is unmapped.
    localparam logic [31:0] REG_BASE = 32'h0000_0000;
    localparam logic [31:0] MEM_BASE = 32'h0000_0800;
    localparam logic [31:0] MAP_END  = 32'h0000_0C00;

endpackage

// File: rtl/peripheral_bus_bridge_if.sv
// Request/response channel between the bus master and the bridge.
interface peripheral_bus_bridge_if #(
    parameter int ADDRWIDTH = 12
);
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_write;
    logic [ADDRWIDTH-1:0] req_addr;
    logic [31:0]          req_wdata;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [31:0]          resp_rdata;
    logic                 resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/peripheral_bus_bridge_addr_decode.sv
// Combinational address decoder: byte address -> target, register index,
// memory word. Build option PERIPH_BRIDGE_STRICT_ALIGN_EN turns any
// non-word-aligned address into an error; otherwise addr[1:0] is ignored.
module peripheral_addr_decode
    import peripheral_bridge_pkg::*;
#(
    parameter int REGS      = 3,
    parameter int ADDRWIDTH = 12,
    parameter int MEMDEPTH  = 256,
    parameter int IDXW      = (REGS > 1) ? $clog2(REGS) : 1
)(
    input  logic [ADDRWIDTH-1:0] addr,
    output target_t              target,
    output logic [IDXW-1:0]      reg_idx,
    output logic [7:0]           mem_word
);
    localparam logic [31:0] MEM_END = MEM_BASE + 32'(MEMDEPTH * 4);

    logic [31:0] addr_ext;
    logic [8:0]  full_idx;
    logic        misaligned;

    // Region lookup, index extraction and range check in one pass.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (which would infer a latch).
        target   = TGT_ERR;
        addr_ext = 32'(addr);
        full_idx = 9'((addr_ext - REG_BASE) >> 2);
        mem_word = 8'((addr_ext - MEM_BASE) >> 2);
        reg_idx  = full_idx[IDXW-1:0];
`ifdef PERIPH_BRIDGE_STRICT_ALIGN_EN
        misaligned = (addr_ext[1:0] != 2'b00);
`else
        misaligned = 1'b0;
`endif
        if (misaligned) begin
            target = TGT_ERR;
        end else if (addr_ext < MEM_BASE) begin
            target = ({23'b0, full_idx} < 32'(REGS)) ? TGT_REG : TGT_ERR;
        end else if ((addr_ext < MEM_END) && (addr_ext < MAP_END)) begin
            target = TGT_MEM;
        end
    end
endmodule

// File: rtl/peripheral_bus_bridge.sv
// Bus-slave front end for the peripheral core: accepts one word request at
// a time, issues one-cycle register/memory strobes and returns a response.
// Build option PERIPH_BRIDGE_STRICT_ALIGN_EN (applied in the decoder) makes
// misaligned addresses return an error.
module peripheral_bus_bridge
    import peripheral_bridge_pkg::*;
#(
    parameter int REGS      = 3,
    parameter int ADDRWIDTH = 12,
    parameter int MEMDEPTH  = 256
)(
    input  logic                  clk,
    input  logic                  reset,
    peripheral_bus_bridge_if.slave bus,
    output logic [REGS-1:0]       reg_write_en,
    output logic [31:0]           reg_data_in,
    input  logic [REGS-1:0][31:0] reg_data_out,
    output logic                  mem_write_en,
    output logic [7:0]            mem_address,
    output logic [31:0]           mem_data_in,
    input  logic [31:0]           mem_data_out
);
    localparam int IDXW = (REGS > 1) ? $clog2(REGS) : 1;

    localparam logic [1:0] S_IDLE     = IDLE;
    localparam logic [1:0] S_ACCESS   = ACCESS;
    localparam logic [1:0] S_MEM_WAIT = MEM_WAIT;
    localparam logic [1:0] S_RESP     = RESP;

    logic [1:0]      state;
    logic            write_q;
    target_t         tgt_q;
    logic [IDXW-1:0] idx_q;
    logic            resp_valid_q;
    logic [31:0]     resp_rdata_q;
    logic            resp_err_q;

    target_t         dec_target;
    logic [IDXW-1:0] dec_idx;
    logic [7:0]      dec_word;

    peripheral_addr_decode #(
        .REGS      (REGS),
        .ADDRWIDTH (ADDRWIDTH),
        .MEMDEPTH  (MEMDEPTH),
        .IDXW      (IDXW)
    ) u_decode (
        .addr     (bus.req_addr),
        .target   (dec_target),
        .reg_idx  (dec_idx),
        .mem_word (dec_word)
    );

    // Ready only in IDLE and never while reset is held.
    assign bus.req_ready  = (state == S_IDLE) && reset;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;

    // Transaction FSM; strobes are loaded on acceptance so they are live
    // exactly for the ACCESS cycle, then fall back to their defaults.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            write_q      <= 1'b0;
            tgt_q        <= TGT_ERR;
            idx_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            reg_write_en <= '0;
            reg_data_in  <= '0;
            mem_write_en <= 1'b0;
            mem_address  <= '0;
            mem_data_in  <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout; the defaults below are overridden later in the same block only on the accept edge.
            reg_write_en <= '0;
            reg_data_in  <= '0;
            mem_write_en <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        write_q      <= bus.req_write;
                        tgt_q        <= dec_target;
                        idx_q        <= dec_idx;
                        resp_rdata_q <= '0;
                        if (dec_target == TGT_ERR) begin
                            resp_err_q   <= 1'b1;
                            resp_valid_q <= 1'b1;
                            state        <= S_RESP;
                        end else begin
                            resp_err_q <= 1'b0;
                            state      <= S_ACCESS;
                            if (dec_target == TGT_REG) begin
                                if (bus.req_write) begin
                                    reg_write_en <= REGS'(1) << dec_idx;
                                    reg_data_in  <= bus.req_wdata;
                                end
                            end else begin
                                mem_address <= dec_word;
                                if (bus.req_write) begin
                                    mem_write_en <= 1'b1;
                                    mem_data_in  <= bus.req_wdata;
                                end
                            end
                        end
                    end
                end
                S_ACCESS: begin
                    if ((tgt_q == TGT_MEM) && !write_q) begin
                        state <= S_MEM_WAIT;
                    end else begin
                        if ((tgt_q == TGT_REG) && !write_q) begin
                            resp_rdata_q <= reg_data_out[idx_q];
                        end
                        resp_valid_q <= 1'b1;
                        state        <= S_RESP;
                    end
                end
                S_MEM_WAIT: begin
                    resp_rdata_q <= mem_data_out;
                    resp_valid_q <= 1'b1;
                    state        <= S_RESP;
                end
                S_RESP: begin
                    if (bus.resp_ready) begin
                        resp_valid_q <= 1'b0;
                        state        <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_peripheral_bus_bridge.sv
// Self-checking bench for peripheral_bus_bridge: directed cases from the
// address map plus randomized requests, scored against a map-level model.
`timescale 1ns/1ps
module tb_peripheral_bus_bridge;
    localparam int REGS = 3;
`ifdef PERIPH_BRIDGE_STRICT_ALIGN_EN
    localparam bit STRICT = 1'b1;
`else
    localparam bit STRICT = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;

    peripheral_bus_bridge_if #(.ADDRWIDTH(12)) bus ();

    logic [REGS-1:0]       reg_write_en;
    logic [31:0]           reg_data_in;
    logic [REGS-1:0][31:0] core_regs;
    logic                  mem_write_en;
    logic [7:0]            mem_address;
    logic [31:0]           mem_data_in;
    logic [31:0]           mem_data_out;
    logic [31:0]           core_mem [256];
    bit                    env_init = 1'b0;

    logic [31:0] exp_regs [REGS];
    logic [31:0] exp_mem  [256];

    int errors = 0;
    int checks = 0;

    peripheral_bus_bridge #(
        .REGS      (REGS),
        .ADDRWIDTH (12),
        .MEMDEPTH  (256)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .reg_write_en (reg_write_en),
        .reg_data_in  (reg_data_in),
        .reg_data_out (core_regs),
        .mem_write_en (mem_write_en),
        .mem_address  (mem_address),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_mem(input int i);
        return 32'h5A00_0000 ^ (32'(i) * 32'h0001_0203);
    endfunction

    function automatic logic [31:0] init_reg(input int i);
        return (i == 2) ? 32'h0000_0001 : 32'hC0DE_0000 + 32'(i);
    endfunction

    // Core model: register file and synchronous memory with 1-cycle read.
    always @(posedge clk) begin
        if (!env_init) begin
            for (int i = 0; i < 256; i++) core_mem[i] <= init_mem(i);
            for (int r = 0; r < REGS; r++) core_regs[r] <= init_reg(r);
            env_init <= 1'b1;
        end else begin
            for (int r = 0; r < REGS; r++)
                if (reg_write_en[r]) core_regs[r] <= reg_data_in;
            if (mem_write_en) core_mem[mem_address] <= mem_data_in;
        end
        mem_data_out <= core_mem[mem_address];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic noise();
        bus.req_valid = 1'($urandom);
        bus.req_write = 1'($urandom);
        bus.req_addr  = 12'($urandom);
        bus.req_wdata = $urandom;
    endtask

    // One complete transaction; called just after a falling edge.
    task automatic txn(input logic wr, input logic [11:0] addr,
                       input logic [31:0] wd, input int stall);
        bit          err, is_mem;
        int          idx, word, exp_lat, exp_reg_cnt, exp_mem_cnt;
        logic [31:0] exp_rd, rd0;
        logic        er0;
        int          cyc, lat, reg_cnt, mem_cnt, bad_strobe, busy_ready, hold_bad;

        err = 1'b0; is_mem = 1'b0; idx = 0; word = 0;
        if (STRICT && (addr[1:0] != 2'b00)) err = 1'b1;
        else if (addr < 12'h800) begin
            idx = int'(addr) / 4;
            if (idx >= REGS) err = 1'b1;
        end else if (addr < 12'hC00) begin
            is_mem = 1'b1;
            word   = (int'(addr) - 'h800) / 4;
        end else err = 1'b1;

        exp_lat     = err ? 1 : ((is_mem && !wr) ? 3 : 2);
        exp_rd      = (err || wr) ? 32'h0 : (is_mem ? exp_mem[word] : exp_regs[idx]);
        exp_reg_cnt = (!err && !is_mem && wr) ? 1 : 0;
        exp_mem_cnt = (!err && is_mem && wr) ? 1 : 0;
        if (!err && wr) begin
            if (is_mem) exp_mem[word] = wd;
            else        exp_regs[idx] = wd;
        end

        bus.req_valid  = 1'b1;
        bus.req_write  = wr;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        bus.resp_ready = 1'b0;
        cyc = 0;
        while (bus.req_ready !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("accept", 32'(bus.req_ready), 32'd1);
        if (bus.req_ready !== 1'b1) begin
            bus.req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        cyc = 1; lat = 0; reg_cnt = 0; mem_cnt = 0; bad_strobe = 0; busy_ready = 0;
        while (cyc <= 8) begin
            noise();
            if (bus.req_ready) busy_ready++;
            if (reg_write_en != '0) begin
                reg_cnt++;
                if (cyc != 1 || reg_write_en != 3'(1 << idx) || reg_data_in != wd) bad_strobe++;
            end
            if (mem_write_en) begin
                mem_cnt++;
                if (cyc != 1 || mem_address != 8'(word) || mem_data_in != wd) bad_strobe++;
            end
            if (bus.resp_valid) begin
                lat = cyc;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        check("latency", 32'(lat), 32'(exp_lat));
        rd0 = bus.resp_rdata;
        er0 = bus.resp_err;
        check("rdata", rd0, exp_rd);
        check("err", 32'(er0), 32'(err));

        hold_bad = 0;
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            noise();
            if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== rd0 || bus.resp_err !== er0) hold_bad++;
            if (bus.req_ready) busy_ready++;
            if (reg_write_en != '0 || mem_write_en) bad_strobe++;
        end
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.resp_ready = 1'b0;
        check("hold_stable", 32'(hold_bad), 32'd0);
        check("busy_ready", 32'(busy_ready), 32'd0);
        check("reg_strobes", 32'(reg_cnt), 32'(exp_reg_cnt));
        check("mem_strobes", 32'(mem_cnt), 32'(exp_mem_cnt));
        check("strobe_value", 32'(bad_strobe), 32'd0);
        check("resp_drop", 32'(bus.resp_valid), 32'd0);
        check("ready_back", 32'(bus.req_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen, sel;
        logic [11:0] a;

        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.resp_ready = 1'b0;
        for (int i = 0; i < 256; i++) exp_mem[i] = init_mem(i);
        for (int r = 0; r < REGS; r++) exp_regs[r] = init_reg(r);

        repeat (3) @(negedge clk);
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_strobes", {29'b0, reg_write_en}, 32'd0);
        check("rst_mem_addr", 32'(mem_address), 32'd0);
        reset = 1'b1;
        #1;
        check("rel_req_ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk);

        txn(1'b1, 12'h004, 32'h0000_0005, 0);
        txn(1'b0, 12'h008, 32'h0, 0);
        txn(1'b1, 12'h810, 32'hDEAD_BEEF, 0);
        txn(1'b0, 12'h810, 32'h0, 0);
        txn(1'b1, 12'h00C, 32'h1111_2222, 0);
        txn(1'b0, 12'hC00, 32'h0, 0);
        txn(1'b0, 12'h000, 32'h0, 5);
        txn(1'b0, 12'h004, 32'h0, 0);

        // Reset during the ACCESS cycle of a memory write.
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 12'h820;
        bus.req_wdata = 32'h1234_5678;
        check("mid_rst_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("mid_rst_strobe", 32'(mem_write_en), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_mem_we", 32'(mem_write_en), 32'd0);
        check("mid_rst_ready", 32'(bus.req_ready), 32'd0);
        check("mid_rst_valid", 32'(bus.resp_valid), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("post_rst_ready", 32'(bus.req_ready), 32'd1);
        check("post_rst_valid", 32'(bus.resp_valid), 32'd0);
        check("post_rst_rdata", bus.resp_rdata, 32'd0);
        check("post_rst_err", 32'(bus.resp_err), 32'd0);
        check("post_rst_reg_we", {29'b0, reg_write_en}, 32'd0);
        check("post_rst_mem_we", 32'(mem_write_en), 32'd0);
        check("post_rst_mem_addr", 32'(mem_address), 32'd0);
        check("post_rst_reg_din", reg_data_in, 32'd0);
        check("post_rst_mem_din", mem_data_in, 32'd0);
        bus.resp_ready = 1'b1;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.resp_valid || mem_write_en || reg_write_en != '0) seen++;
        end
        bus.resp_ready = 1'b0;
        check("no_resp_after_rst", 32'(seen), 32'd0);
        txn(1'b0, 12'h820, 32'h0, 0);

        txn(1'b1, 12'h006, 32'h0000_0077, 0);
        txn(1'b0, 12'h004, 32'h0, 1);

        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(0, 3);
            case (sel)
                0:       a = 12'($urandom_range(0, 31));
                1:       a = 12'h800 + 12'($urandom_range(0, 1023));
                2:       a = 12'($urandom);
                default: a = 12'h800 + 12'($urandom_range(0, 15)) * 12'd4;
            endcase
            txn(1'($urandom), a, $urandom, $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
